multicycle_control: RTL and testbench

Main control state machine for the multicycle MIPS datapath. It fetches, decodes and sequences each instruction over several cycles, driving the datapath mux selects and write strobes. It also drives the 4-bit `alu_op` code consumed by the ALU control decoder. It sits between the instruction register (opcode/funct fields) and the datapath, one instance per core.

---
 rtl/mips_pkg.sv | 88 ++++++++
 rtl/mc_ctrl_decode.sv | 74 +++++++
 rtl/multicycle_control.sv | 107 ++++++++++
 tb/tb_multicycle_control.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: state encodings,
// opcode/funct constants, alu_op codes and the control-strobe bundle.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_JR     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_JR    = 6'd8;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_RTYPE = 4'd2,
    ALU_ADDI  = 4'd3,
    ALU_SLTI  = 4'd4,
    ALU_ANDI  = 4'd5,
    ALU_ORI   = 4'd6,
    ALU_LUI   = 4'd7
  } alu_op_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [1:0] pc_source;
    alu_op_t    alu_op;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_SLTI, OP_ANDI,
      OP_ORI, OP_LUI, OP_LW, OP_SW: is_legal_op = 1'b1;
      default:                      is_legal_op = 1'b0;
    endcase
  endfunction

  function automatic alu_op_t iexec_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI: iexec_alu_op = ALU_SLTI;
      OP_ANDI: iexec_alu_op = ALU_ANDI;
      OP_ORI:  iexec_alu_op = ALU_ORI;
      OP_LUI:  iexec_alu_op = ALU_LUI;
      default: iexec_alu_op = ALU_ADDI;
    endcase
  endfunction

  // States whose exit into FETCH retires an instruction.
  function automatic logic is_final(input state_t s);
    case (s)
      S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_JR: is_final = 1'b1;
      default:                                               is_final = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational Moore decoder: current state (plus opcode where the state
// needs it) to datapath strobes. rdy qualifies the FETCH PC/IR loads.
module mc_ctrl_decode
  import mips_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        rdy,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = rdy;
        ctrl.pc_write  = rdy;
        ctrl.alu_src_b = 2'd1;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = 2'd3;
        ctrl.illegal_op = !is_legal_op(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'd2;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_RTYPE;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'd1;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'd2;
        ctrl.alu_op    = iexec_alu_op(opcode);
        ctrl.zero_ext  = (opcode == OP_ANDI) || (opcode == OP_ORI);
      end
      S_IWB:  ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'd2;
      end
      S_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'd3;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with retired-instruction counter.
// Define MC_CTRL_MEM_WAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             zero_ext,
  output logic [1:0]       pc_source,
  output logic [3:0]       alu_op,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t     state_q, state_d;
  ctrl_t      ctrl, ctrl_g;
  logic       rdy;
  logic [CNT_W-1:0] cnt_q;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (is_final(state_q) && state_d == S_FETCH)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_RTYPE:      state_d = (funct == FN_JR) ? S_JR : S_EXEC;
          OP_BEQ:        state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IEXEC;
          OP_J:          state_d = S_JUMP;
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_dec (
    .state  (state_q),
    .opcode (opcode),
    .rdy    (rdy),
    .ctrl   (ctrl)
  );

  // FETCH decodes to live strobes, so hold everything quiet while in reset.
  assign ctrl_g = rst_n ? ctrl : '0;

  assign pc_write      = ctrl_g.pc_write;
  assign pc_write_cond = ctrl_g.pc_write_cond;
  assign i_or_d        = ctrl_g.i_or_d;
  assign mem_read      = ctrl_g.mem_read;
  assign mem_write     = ctrl_g.mem_write;
  assign ir_write      = ctrl_g.ir_write;
  assign mem_to_reg    = ctrl_g.mem_to_reg;
  assign reg_dst       = ctrl_g.reg_dst;
  assign reg_write     = ctrl_g.reg_write;
  assign alu_src_a     = ctrl_g.alu_src_a;
  assign alu_src_b     = ctrl_g.alu_src_b;
  assign zero_ext      = ctrl_g.zero_ext;
  assign pc_source     = ctrl_g.pc_source;
  assign alu_op        = ctrl_g.alu_op;
  assign illegal_op    = ctrl_g.illegal_op;
  assign state         = state_q;
  assign instr_count   = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-cycle expected
// control vectors, a negedge monitor pops and compares them.
module tb_multicycle_control;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic             mem_ready = 1'b1;
  logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic             mem_to_reg, reg_dst, reg_write, alu_src_a, zero_ext, illegal_op;
  logic [1:0]       alu_src_b, pc_source;
  logic [3:0]       alu_op, state;
  logic [CNT_W-1:0] instr_count;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .zero_ext(zero_ext),
    .pc_source(pc_source), .alu_op(alu_op), .illegal_op(illegal_op),
    .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // {state, pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, zx, pcs, aluop, ill}
  logic [23:0] act;
  assign act = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, zero_ext,
                pc_source, alu_op, illegal_op};

  typedef struct {
    logic [23:0]      vec;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               n_chk = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  // Expected strobes straight from the state table of the control description.
  function automatic logic [23:0] exp_vec(input int st, input logic [5:0] op, input logic rdy);
    logic       pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, zx, ill;
    logic [1:0] asb, pcs;
    logic [3:0] aop, s;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, zx, ill} = '0;
    asb = 2'd0; pcs = 2'd0; aop = 4'd0; s = 4'(st);
    case (st)
      0:  begin mr = 1; irw = rdy; pcw = rdy; asb = 2'd1; end
      1:  begin
            asb = 2'd3;
            ill = !(op inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd10, 6'd12, 6'd13, 6'd15, 6'd35, 6'd43});
          end
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 4'd2; end
      7:  begin rw = 1; rdst = 1; end
      8:  begin asa = 1; aop = 4'd1; pcwc = 1; pcs = 2'd1; end
      9:  begin
            asa = 1; asb = 2'd2;
            case (op)
              6'd10: aop = 4'd4;
              6'd12: begin aop = 4'd5; zx = 1; end
              6'd13: begin aop = 4'd6; zx = 1; end
              6'd15: aop = 4'd7;
              default: aop = 4'd3;
            endcase
          end
      10: rw = 1;
      11: begin pcw = 1; pcs = 2'd2; end
      12: begin pcw = 1; pcs = 2'd3; end
      default: ;
    endcase
    return {s, pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, zx, pcs, aop, ill};
  endfunction

  task automatic push(input int st, input logic [5:0] op, input logic rdy);
    exp_t e;
    e.vec = exp_vec(st, op, rdy);
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  // Issue one instruction; seq lists the hand-derived state walk. Caller is at posedge+1.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int n,
                           input int seq [5]);
    opcode = op;
    funct  = fn;
    for (int i = 0; i < n; i++) push(seq[i], op, 1'b1);
    repeat (n) @(posedge clk);
    #1;
    if (seq[n-1] != 1) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic chk_now(input string name, input logic [23:0] v, input logic [CNT_W-1:0] c);
    n_chk++;
    if (act !== v || instr_count !== c) begin
      n_fail++;
      $display("FAIL %s: got ctrl=%h cnt=%0d, want ctrl=%h cnt=%0d", name, act, instr_count, v, c);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared at negedge.
  int step = 0;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      step++;
      n_chk++;
      if (act !== e.vec || instr_count !== e.cnt) begin
        n_fail++;
        $display("FAIL cycle%0d: got state=%0d ctrl=%h cnt=%0d, want state=%0d ctrl=%h cnt=%0d",
                 step, state, act, instr_count, e.vec[23:20], e.vec, e.cnt);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk_now("reset_quiet", 24'h0, '0);
    rst_n = 1'b1;

    run_instr(6'd35, 6'd0,  5, '{0, 1, 2, 3, 4});   // lw
    run_instr(6'd0,  6'd32, 4, '{0, 1, 6, 7, 0});   // add
    run_instr(6'd0,  6'd8,  3, '{0, 1, 12, 0, 0});  // jr
    run_instr(6'd13, 6'd0,  4, '{0, 1, 9, 10, 0});  // ori
    run_instr(6'd4,  6'd0,  3, '{0, 1, 8, 0, 0});   // beq
    run_instr(6'd63, 6'd0,  2, '{0, 1, 0, 0, 0});   // illegal
    run_instr(6'd8,  6'd0,  4, '{0, 1, 9, 10, 0});  // addi
    run_instr(6'd10, 6'd0,  4, '{0, 1, 9, 10, 0});  // slti
    run_instr(6'd12, 6'd0,  4, '{0, 1, 9, 10, 0});  // andi
    run_instr(6'd15, 6'd0,  4, '{0, 1, 9, 10, 0});  // lui
    run_instr(6'd43, 6'd0,  4, '{0, 1, 2, 5, 0});   // sw
    run_instr(6'd1,  6'd0,  2, '{0, 1, 0, 0, 0});   // illegal (regimm unsupported)
    run_instr(6'd2,  6'd0,  3, '{0, 1, 11, 0, 0});  // j

`ifdef MC_CTRL_MEM_WAIT_EN
    // FETCH stalled three cycles: read held, PC/IR load only on the ready cycle.
    opcode = 6'd2;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 6'd2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    run_instr(6'd2, 6'd0, 3, '{0, 1, 11, 0, 0});
`endif

    // sw interrupted by reset in MEMWR.
    opcode = 6'd43;
    funct  = 6'd0;
    push(0, 6'd43, 1'b1); push(1, 6'd43, 1'b1); push(2, 6'd43, 1'b1); push(5, 6'd43, 1'b1);
    repeat (3) @(posedge clk);
    #6;
    rst_n = 1'b0;
    #1;
    chk_now("reset_in_memwr", 24'h0, '0);
    @(posedge clk); #1;
    chk_now("reset_held", 24'h0, '0);
    rst_n = 1'b1;
    exp_cnt = '0;
    run_instr(6'd2, 6'd0, 3, '{0, 1, 11, 0, 0});    // j after reset
    run_instr(6'd35, 6'd0, 5, '{0, 1, 2, 3, 4});    // lw, count 1 -> 2
    push(0, 6'd35, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
